// File: rtl/axi_user_arbiter.sv
// N-channel arbiter sharing the single user-side port of the AXI read/write bridge.
// Round-robin by default; define AXI_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module axi_user_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned BLKS_W = 8,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*3-1:0]      ch_size_i,
  input  logic [NUM_CH*BLKS_W-1:0] ch_blks_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [1:0]               ch_resp_o,
  output logic                     user_valid_o,
  output logic                     user_req_o,
  output logic [ADDR_W-1:0]        user_addr_o,
  output logic [2:0]               user_size_o,
  output logic [BLKS_W-1:0]        user_blks_o,
  output logic [DATA_W-1:0]        user_wdata_o,
  input  logic                     user_ready_i,
  input  logic [DATA_W-1:0]        user_rdata_i,
  input  logic [1:0]               user_resp_i,
  output logic [CH_W-1:0]          grant_o,
  output logic                     busy_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic            busy_q, busy_d;
  logic [CH_W-1:0] pick;
  logic            any_req;

  assign any_req = |ch_valid_i;

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Lowest requesting index wins; no history is kept.
  always_comb begin
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_valid_i[k]) pick = CH_W'(k);
    end
  end
`else
  logic [CH_W-1:0]   last_q, last_d;
  logic [NUM_CH-1:0] upper_req;
  logic [CH_W-1:0]   pick_upper, pick_any;

  // Prefer the lowest requester above the last grant, else wrap to the lowest overall.
  // Only indices below NUM_CH are ever produced, so non-power-of-two counts are safe.
  always_comb begin
    upper_req  = '0;
    pick_upper = '0;
    pick_any   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      upper_req[k] = ch_valid_i[k] && (CH_W'(k) > last_q);
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (upper_req[k])  pick_upper = CH_W'(k);
      if (ch_valid_i[k]) pick_any   = CH_W'(k);
    end
    pick = (|upper_req) ? pick_upper : pick_any;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StBusy && user_ready_i) last_d = grant_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= CH_W'(NUM_CH - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StBusy;
          grant_d = pick;
          busy_d  = 1'b1;
        end
      end
      StBusy: begin
        // A withdrawn request does not abort; only the bridge done pulse ends the grant.
        if (user_ready_i) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  // Request fields follow the granted channel; meaningful only while user_valid_o is high.
  always_comb begin
    user_req_o   = 1'b0;
    user_addr_o  = '0;
    user_size_o  = '0;
    user_blks_o  = '0;
    user_wdata_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q == CH_W'(k)) begin
        user_req_o   = ch_req_i[k];
        user_addr_o  = ch_addr_i[k*ADDR_W +: ADDR_W];
        user_size_o  = ch_size_i[k*3 +: 3];
        user_blks_o  = ch_blks_i[k*BLKS_W +: BLKS_W];
        user_wdata_o = ch_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ch_ready_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_ready_o[k] = (state_q == StBusy) && user_ready_i && (grant_q == CH_W'(k));
    end
  end

  assign user_valid_o = (state_q == StBusy);
  assign ch_rdata_o   = user_rdata_i;
  assign ch_resp_o    = user_resp_i;
  assign grant_o      = grant_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Directed self-checking bench for axi_user_arbiter: a 2-channel and a 3-channel instance.
module tb_axi_user_arbiter;

`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned BW = 8;
  localparam int unsigned TAW = 32;
  localparam int unsigned TDW = 32;

  int errors = 0;
  int checks = 0;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Two-channel instance
  logic [1:0]      ch_valid, ch_req, ch_ready;
  logic [2*AW-1:0] ch_addr;
  logic [5:0]      ch_size;
  logic [2*BW-1:0] ch_blks;
  logic [2*DW-1:0] ch_wdata;
  logic [DW-1:0]   ch_rdata;
  logic [1:0]      ch_resp;
  logic            u_valid, u_req, u_ready, busy;
  logic [AW-1:0]   u_addr;
  logic [2:0]      u_size;
  logic [BW-1:0]   u_blks;
  logic [DW-1:0]   u_wdata, u_rdata;
  logic [1:0]      u_resp;
  logic [0:0]      grant;

  axi_user_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .BLKS_W(BW)) dut (
    .clock(clock), .reset(reset),
    .ch_valid_i(ch_valid), .ch_req_i(ch_req), .ch_addr_i(ch_addr), .ch_size_i(ch_size),
    .ch_blks_i(ch_blks), .ch_wdata_i(ch_wdata), .ch_ready_o(ch_ready), .ch_rdata_o(ch_rdata),
    .ch_resp_o(ch_resp), .user_valid_o(u_valid), .user_req_o(u_req), .user_addr_o(u_addr),
    .user_size_o(u_size), .user_blks_o(u_blks), .user_wdata_o(u_wdata),
    .user_ready_i(u_ready), .user_rdata_i(u_rdata), .user_resp_i(u_resp),
    .grant_o(grant), .busy_o(busy)
  );

  // Three-channel instance (non-power-of-two wrap)
  logic [2:0]       t_valid, t_req, t_ch_ready;
  logic [3*TAW-1:0] t_addr;
  logic [8:0]       t_size;
  logic [3*BW-1:0]  t_blks;
  logic [3*TDW-1:0] t_wdata;
  logic [TDW-1:0]   t_rdata, t_u_wdata, t_u_rdata;
  logic [1:0]       t_resp, t_u_resp, t_grant;
  logic             t_u_valid, t_u_req, t_u_ready, t_busy;
  logic [TAW-1:0]   t_u_addr;
  logic [2:0]       t_u_size;
  logic [BW-1:0]    t_u_blks;

  axi_user_arbiter #(.NUM_CH(3), .ADDR_W(TAW), .DATA_W(TDW), .BLKS_W(BW)) dut3 (
    .clock(clock), .reset(reset),
    .ch_valid_i(t_valid), .ch_req_i(t_req), .ch_addr_i(t_addr), .ch_size_i(t_size),
    .ch_blks_i(t_blks), .ch_wdata_i(t_wdata), .ch_ready_o(t_ch_ready), .ch_rdata_o(t_rdata),
    .ch_resp_o(t_resp), .user_valid_o(t_u_valid), .user_req_o(t_u_req),
    .user_addr_o(t_u_addr), .user_size_o(t_u_size), .user_blks_o(t_u_blks),
    .user_wdata_o(t_u_wdata), .user_ready_i(t_u_ready), .user_rdata_i(t_u_rdata),
    .user_resp_i(t_u_resp), .grant_o(t_grant), .busy_o(t_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse the bridge done for one cycle and expect it routed to channel g only.
  task automatic finish2(input int g);
    logic [1:0] e;
    e = 2'(1 << g);
    u_ready = 1'b1;
    #1;
    checks++;
    if (ch_ready !== e) begin
      errors++; $error("FAIL ch_ready_pulse: observed=%0h expected=%0h", ch_ready, e);
    end
    tick();
    u_ready = 1'b0;
    checks++;
    if (ch_ready !== 2'b00) begin
      errors++; $error("FAIL ready_one_cycle: observed=%0h", ch_ready);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $error("FAIL busy_fall: observed=%0h", busy);
    end
    checks++;
    if (u_valid !== 1'b0) begin
      errors++; $error("FAIL idle_gap: observed=%0h", u_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b1;
    ch_valid = '0; ch_req = '0; ch_addr = '0; ch_size = '0; ch_blks = '0; ch_wdata = '0;
    u_ready = 1'b0; u_rdata = '0; u_resp = '0;
    t_valid = '0; t_req = '0; t_addr = '0; t_size = '0; t_blks = '0; t_wdata = '0;
    t_u_ready = 1'b0; t_u_rdata = '0; t_u_resp = '0;
    repeat (2) tick();

    // Reset state
    checks++;
    if (busy !== 1'b0) begin errors++; $error("FAIL rst_busy: observed=%0h", busy); end
    checks++;
    if (u_valid !== 1'b0) begin errors++; $error("FAIL rst_valid: observed=%0h", u_valid); end
    checks++;
    if (grant !== 1'b0) begin errors++; $error("FAIL rst_grant: observed=%0h", grant); end
    checks++;
    if (ch_ready !== 2'b00) begin errors++; $error("FAIL rst_ready: observed=%0h", ch_ready); end
    checks++;
    if (t_grant !== 2'd0) begin errors++; $error("FAIL rst3_grant: observed=%0h", t_grant); end
    checks++;
    if (t_u_valid !== 1'b0) begin
      errors++; $error("FAIL rst3_valid: observed=%0h", t_u_valid);
    end
    reset = 1'b0;

    // Broadcast paths
    u_rdata = {16{32'hDEADBEEF}};
    u_resp  = 2'b10;
    #1;
    checks++;
    if (ch_rdata !== {16{32'hDEADBEEF}}) begin
      errors++; $error("FAIL bcast_rdata: observed=%0h", ch_rdata);
    end
    checks++;
    if (ch_resp !== 2'b10) begin errors++; $error("FAIL bcast_resp: observed=%0h", ch_resp); end

    // Single read request on channel 1, bridge done 5 cycles later
    ch_valid = 2'b10;
    ch_addr[AW +: AW] = 64'h8000_0000;
    ch_blks[BW +: BW] = 8'd1;
    tick();
    checks++;
    if (u_valid !== 1'b1) begin errors++; $error("FAIL single_valid: observed=%0h", u_valid); end
    checks++;
    if (grant !== 1'b1) begin errors++; $error("FAIL single_grant: observed=%0h", grant); end
    checks++;
    if (busy !== 1'b1) begin errors++; $error("FAIL single_busy: observed=%0h", busy); end
    checks++;
    if (u_addr !== 64'h8000_0000) begin
      errors++; $error("FAIL single_addr: observed=%0h", u_addr);
    end
    checks++;
    if (u_req !== 1'b0) begin errors++; $error("FAIL single_req: observed=%0h", u_req); end
    checks++;
    if (u_blks !== 8'd1) begin errors++; $error("FAIL single_blks: observed=%0h", u_blks); end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $error("FAIL single_wait_busy: observed=%0h", busy); end
    checks++;
    if (ch_ready !== 2'b00) begin
      errors++; $error("FAIL single_wait_ready: observed=%0h", ch_ready);
    end
    finish2(1);
    ch_valid = 2'b00;

    // Contention with both requests held
    ch_valid = 2'b11;
    ch_addr[0 +: AW]  = 64'h1000;
    ch_addr[AW +: AW] = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      g = RR ? (i % 2) : 0;
      tick();
      checks++;
      if (grant !== 1'(g)) begin
        errors++; $error("FAIL cont_grant: observed=%0h expected=%0h", grant, g);
      end
      checks++;
      if (u_valid !== 1'b1) begin errors++; $error("FAIL cont_valid: observed=%0h", u_valid); end
      checks++;
      if (u_addr !== ((g == 1) ? 64'h2000 : 64'h1000)) begin
        errors++; $error("FAIL cont_addr: observed=%0h", u_addr);
      end
      finish2(g);
    end
    ch_valid = 2'b00;

    // Write mux on channel 1; channel 0 changes while busy must not leak through
    ch_valid = 2'b10;
    ch_req   = 2'b10;
    ch_wdata[DW +: DW] = {64{8'hA5}};
    ch_size[3 +: 3]    = 3'b011;
    ch_addr[AW +: AW]  = 64'h3000;
    ch_blks[BW +: BW]  = 8'd4;
    tick();
    checks++;
    if (grant !== 1'b1) begin errors++; $error("FAIL wr_grant: observed=%0h", grant); end
    checks++;
    if (u_req !== 1'b1) begin errors++; $error("FAIL wr_req: observed=%0h", u_req); end
    checks++;
    if (u_wdata !== {64{8'hA5}}) begin errors++; $error("FAIL wr_wdata: observed=%0h", u_wdata); end
    checks++;
    if (u_size !== 3'b011) begin errors++; $error("FAIL wr_size: observed=%0h", u_size); end
    ch_valid = 2'b11;
    ch_wdata[0 +: DW] = {64{8'h5A}};
    ch_size[0 +: 3]   = 3'b111;
    ch_addr[0 +: AW]  = 64'h4000;
    tick();
    checks++;
    if (grant !== 1'b1) begin errors++; $error("FAIL wr_hold_grant: observed=%0h", grant); end
    checks++;
    if (u_wdata !== {64{8'hA5}}) begin
      errors++; $error("FAIL wr_hold_wdata: observed=%0h", u_wdata);
    end
    checks++;
    if (u_size !== 3'b011) begin errors++; $error("FAIL wr_hold_size: observed=%0h", u_size); end
    checks++;
    if (u_addr !== 64'h3000) begin errors++; $error("FAIL wr_hold_addr: observed=%0h", u_addr); end
    checks++;
    if (u_req !== 1'b1) begin errors++; $error("FAIL wr_hold_req: observed=%0h", u_req); end
    finish2(1);
    ch_valid = 2'b01;
    tick();
    checks++;
    if (grant !== 1'b0) begin errors++; $error("FAIL ch0_grant: observed=%0h", grant); end
    checks++;
    if (u_addr !== 64'h4000) begin errors++; $error("FAIL ch0_addr: observed=%0h", u_addr); end
    checks++;
    if (u_size !== 3'b111) begin errors++; $error("FAIL ch0_size: observed=%0h", u_size); end
    checks++;
    if (u_req !== 1'b0) begin errors++; $error("FAIL ch0_req: observed=%0h", u_req); end

    // Withdrawn request keeps the grant until done
    ch_valid = 2'b00;
    tick();
    checks++;
    if (u_valid !== 1'b1) begin
      errors++; $error("FAIL withdraw_valid: observed=%0h", u_valid);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $error("FAIL withdraw_busy: observed=%0h", busy); end
    finish2(0);

    // Stray ready while idle
    u_ready = 1'b1;
    #1;
    checks++;
    if (ch_ready !== 2'b00) begin errors++; $error("FAIL stray_ready: observed=%0h", ch_ready); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $error("FAIL stray_busy: observed=%0h", busy); end
    checks++;
    if (u_valid !== 1'b0) begin errors++; $error("FAIL stray_valid: observed=%0h", u_valid); end
    u_ready = 1'b0;

    // Reset in the middle of a transaction
    ch_valid = 2'b11;
    tick();
    checks++;
    if (grant !== (RR ? 1'b1 : 1'b0)) begin
      errors++; $error("FAIL mid_grant: observed=%0h", grant);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $error("FAIL mid_busy: observed=%0h", busy); end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (u_valid !== 1'b0) begin errors++; $error("FAIL mid_rst_valid: observed=%0h", u_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $error("FAIL mid_rst_busy: observed=%0h", busy); end
    checks++;
    if (grant !== 1'b0) begin errors++; $error("FAIL mid_rst_grant: observed=%0h", grant); end
    reset = 1'b0;
    tick();
    checks++;
    if (grant !== 1'b0) begin errors++; $error("FAIL post_rst_grant: observed=%0h", grant); end
    checks++;
    if (u_valid !== 1'b1) begin
      errors++; $error("FAIL post_rst_valid: observed=%0h", u_valid);
    end
    finish2(0);
    ch_valid = 2'b00;

    // Three channels all requesting for seven transactions
    for (int k = 0; k < 3; k++) t_addr[k*TAW +: TAW] = 32'h100 * (k + 1);
    t_valid = 3'b111;
    for (int i = 0; i < 7; i++) begin
      g = RR ? (i % 3) : 0;
      tick();
      checks++;
      if (t_grant !== 2'(g)) begin
        errors++; $error("FAIL rr3_grant: observed=%0h expected=%0h", t_grant, g);
      end
      checks++;
      if (t_grant >= 2'd3) begin errors++; $error("FAIL rr3_in_range: observed=%0h", t_grant); end
      checks++;
      if (t_u_addr !== 32'(32'h100 * (g + 1))) begin
        errors++; $error("FAIL rr3_addr: observed=%0h", t_u_addr);
      end
      t_u_ready = 1'b1;
      #1;
      checks++;
      if (t_ch_ready !== 3'(1 << g)) begin
        errors++; $error("FAIL rr3_ready: observed=%0h", t_ch_ready);
      end
      tick();
      t_u_ready = 1'b0;
      checks++;
      if (t_u_valid !== 1'b0) begin errors++; $error("FAIL rr3_gap: observed=%0h", t_u_valid); end
    end
    t_valid = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
